// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor pipeline.
//   DATA_W, REG_ADDR_W : default datapath and GPR index widths
//   OP_*               : two-bit operation encoding driven by execute
//   state_t            : memory-stage control state
package proc_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 2;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage, between execute and writeback.
// ALU results pass straight through to writeback; LOAD/STORE run one req/ack
// transaction on the data-memory bus, abandoned after TIMEOUT request cycles.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_valid / o_ready     execute handshake (transfer when both high)
//   i_op                  00 ALU, 01 LOAD, 10 STORE, 11 NOP
//   i_alu_result          ALU result, or effective address for LOAD/STORE
//   i_store_data          STORE write data
//   i_dest_reg_addr       destination GPR
//   o_mem_req/we/addr/wdata, i_mem_ack, i_mem_rdata   data-memory bus
//   o_wb_enable/dest_reg_addr/data                    registered writeback triple
//   o_fault, i_fault_clear                            sticky timeout flag and its clear
module mem_stage #(
    parameter int unsigned DATA_W     = proc_pkg::DATA_W,
    parameter int unsigned MEM_ADDR_W = 8,
    parameter int unsigned REG_ADDR_W = proc_pkg::REG_ADDR_W,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    input  logic [1:0]            i_op,
    input  logic [DATA_W-1:0]     i_alu_result,
    input  logic [DATA_W-1:0]     i_store_data,
    input  logic [REG_ADDR_W-1:0] i_dest_reg_addr,
    output logic                  o_ready,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_wb_enable,
    output logic [REG_ADDR_W-1:0] o_wb_dest_reg_addr,
    output logic [DATA_W-1:0]     o_wb_data,
    output logic                  o_fault,
    input  logic                  i_fault_clear
);

    import proc_pkg::*;

    // Counter wide enough for the full legal TIMEOUT range (1..255).
    localparam int unsigned CNT_W = 8;
    // Counter value seen in the last permitted request cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_dest;

    assign o_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_dest             <= '0;
            o_mem_req          <= 1'b0;
            o_mem_we           <= 1'b0;
            o_mem_addr         <= '0;
            o_mem_wdata        <= '0;
            o_wb_enable        <= 1'b0;
            o_wb_dest_reg_addr <= '0;
            o_wb_data          <= '0;
            o_fault            <= 1'b0;
        end else begin
            // Writeback is a single-cycle pulse; fields read as zero when idle.
            o_wb_enable        <= 1'b0;
            o_wb_dest_reg_addr <= '0;
            o_wb_data          <= '0;

            // A timeout below overrides this, so set beats a simultaneous clear.
            if (i_fault_clear) begin
                o_fault <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        unique case (i_op)
                            OP_ALU: begin
                                o_wb_enable        <= 1'b1;
                                o_wb_dest_reg_addr <= i_dest_reg_addr;
                                o_wb_data          <= i_alu_result;
                            end
                            OP_LOAD, OP_STORE: begin
                                r_state     <= MEM;
                                r_cnt       <= '0;
                                r_dest      <= i_dest_reg_addr;
                                o_mem_req   <= 1'b1;
                                o_mem_we    <= (i_op == OP_STORE);
                                o_mem_addr  <= i_alu_result[MEM_ADDR_W-1:0];
                                o_mem_wdata <= (i_op == OP_STORE) ? i_store_data : '0;
                            end
                            default: begin
                                // NOP: accepted, nothing to do.
                            end
                        endcase
                    end
                end

                MEM: begin
                    if (i_mem_ack) begin
                        // Ack in the final permitted cycle still completes normally.
                        r_state     <= IDLE;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        if (!o_mem_we) begin
                            o_wb_enable        <= 1'b1;
                            o_wb_dest_reg_addr <= r_dest;
                            o_wb_data          <= i_mem_rdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= IDLE;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_fault     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import proc_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_valid;
    logic [1:0] i_op;
    logic [7:0] i_alu_result;
    logic [7:0] i_store_data;
    logic [1:0] i_dest_reg_addr;
    logic       o_ready;
    logic       o_mem_req;
    logic       o_mem_we;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_wdata;
    logic       i_mem_ack;
    logic [7:0] i_mem_rdata;
    logic       o_wb_enable;
    logic [1:0] o_wb_dest_reg_addr;
    logic [7:0] o_wb_data;
    logic       o_fault;
    logic       i_fault_clear;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DATA_W    (8),
        .MEM_ADDR_W(8),
        .REG_ADDR_W(2),
        .TIMEOUT   (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_valid           (i_valid),
        .i_op              (i_op),
        .i_alu_result      (i_alu_result),
        .i_store_data      (i_store_data),
        .i_dest_reg_addr   (i_dest_reg_addr),
        .o_ready           (o_ready),
        .o_mem_req         (o_mem_req),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_ack         (i_mem_ack),
        .i_mem_rdata       (i_mem_rdata),
        .o_wb_enable       (o_wb_enable),
        .o_wb_dest_reg_addr(o_wb_dest_reg_addr),
        .o_wb_data         (o_wb_data),
        .o_fault           (o_fault),
        .i_fault_clear     (i_fault_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, actual=hung required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, then plays the memory side: acks on request
    // cycle ack_at (0 = never). Returns after the request drops, i.e. in the
    // cycle where the instruction's writeback (if any) is visible.
    task automatic run_instr(input logic [1:0] op, input logic [7:0] alu, input logic [7:0] sd,
                             input logic [1:0] dest, input int ack_at, input logic [7:0] rd,
                             output int n_req);
        i_valid         = 1'b1;
        i_op            = op;
        i_alu_result    = alu;
        i_store_data    = sd;
        i_dest_reg_addr = dest;
        step();
        i_valid         = 1'b0;
        i_op            = 2'($urandom);
        i_alu_result    = 8'($urandom);
        i_store_data    = 8'($urandom);
        i_dest_reg_addr = 2'($urandom);
        n_req = 0;
        while (o_mem_req && n_req < 40) begin
            n_req++;
            chk("req_addr", o_mem_addr, alu);
            chk("req_we", o_mem_we, (op == OP_STORE));
            chk("req_wdata", o_mem_wdata, (op == OP_STORE) ? sd : 8'h00);
            chk("ready_busy", o_ready, 0);
            chk("wb_during_req", o_wb_enable, 0);
            if (n_req == ack_at) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = rd;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = 8'($urandom);
            end
            step();
            i_mem_ack = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] alu;
        logic [7:0] sd;
        logic [1:0] dest;
        int         ack_at;
        logic [7:0] rd;
        logic       exp_en;
        logic [1:0] exp_dest;
        logic [7:0] exp_data;
        int         exp_nreq;
        logic       exp_fault;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int         n;
        logic [1:0] op;
        logic [7:0] alu, sd, rd;
        logic [1:0] dest;
        int         ack_at;
        bit         is_mem, acked, e_en;
        bit         fault_exp;

        tbl[0] = '{OP_ALU,   8'h3C, 8'h00, 2'd1, 0,  8'h00, 1'b1, 2'd1, 8'h3C, 0,   1'b0};
        tbl[1] = '{OP_ALU,   8'hA5, 8'h00, 2'd2, 0,  8'h00, 1'b1, 2'd2, 8'hA5, 0,   1'b0};
        tbl[2] = '{OP_LOAD,  8'h40, 8'h00, 2'd3, 3,  8'h7E, 1'b1, 2'd3, 8'h7E, 3,   1'b0};
        tbl[3] = '{OP_STORE, 8'h10, 8'h99, 2'd0, 1,  8'h00, 1'b0, 2'd0, 8'h00, 1,   1'b0};
        tbl[4] = '{OP_NOP,   8'h55, 8'h66, 2'd2, 0,  8'h00, 1'b0, 2'd0, 8'h00, 0,   1'b0};
        tbl[5] = '{OP_LOAD,  8'h22, 8'h00, 2'd1, 15, 8'hC3, 1'b1, 2'd1, 8'hC3, TMO, 1'b0};
        tbl[6] = '{OP_STORE, 8'h80, 8'h5A, 2'd3, 2,  8'h00, 1'b0, 2'd0, 8'h00, 2,   1'b0};
        tbl[7] = '{OP_LOAD,  8'h40, 8'h00, 2'd2, 0,  8'hEE, 1'b0, 2'd0, 8'h00, TMO, 1'b1};

        reset_n = 1'b0;
        i_valid = 1'b0; i_op = OP_NOP; i_alu_result = '0; i_store_data = '0;
        i_dest_reg_addr = '0; i_mem_ack = 1'b0; i_mem_rdata = '0; i_fault_clear = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_ready", o_ready, 1);
        chk("rst_req", o_mem_req, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_wb_en", o_wb_enable, 0);
        chk("rst_wb_dest", o_wb_dest_reg_addr, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_fault", o_fault, 0);
        reset_n = 1'b1;
        step();
        chk("idle_ready", o_ready, 1);
        chk("idle_wb_en", o_wb_enable, 0);

        // Directed table, issued back to back
        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].op, tbl[i].alu, tbl[i].sd, tbl[i].dest, tbl[i].ack_at,
                      tbl[i].rd, n);
            chk($sformatf("tbl%0d_nreq", i), n, tbl[i].exp_nreq);
            chk($sformatf("tbl%0d_wb_en", i), o_wb_enable, tbl[i].exp_en);
            chk($sformatf("tbl%0d_wb_dest", i), o_wb_dest_reg_addr, tbl[i].exp_dest);
            chk($sformatf("tbl%0d_wb_data", i), o_wb_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_fault", i), o_fault, tbl[i].exp_fault);
            chk($sformatf("tbl%0d_ready", i), o_ready, 1);
        end

        // Late ack in IDLE is ignored
        i_mem_ack = 1'b1; i_mem_rdata = 8'hBD;
        step();
        i_mem_ack = 1'b0;
        chk("late_ack_wb", o_wb_enable, 0);
        chk("late_ack_req", o_mem_req, 0);
        chk("late_ack_fault", o_fault, 1);

        // Fault clear takes effect the next cycle
        i_fault_clear = 1'b1;
        step();
        i_fault_clear = 1'b0;
        chk("fault_cleared", o_fault, 0);

        // Clear held through a timeout: set wins in the final cycle
        i_fault_clear = 1'b1;
        run_instr(OP_LOAD, 8'h33, 8'h00, 2'd1, 0, 8'h00, n);
        chk("setclr_nreq", n, TMO);
        chk("setclr_fault", o_fault, 1);
        step();
        i_fault_clear = 1'b0;
        chk("setclr_after", o_fault, 0);

        // Reset during the second request cycle of a LOAD
        i_valid = 1'b1; i_op = OP_LOAD; i_alu_result = 8'h61; i_dest_reg_addr = 2'd3;
        step();
        i_valid = 1'b0;
        chk("rstmid_req1", o_mem_req, 1);
        step();
        chk("rstmid_req2", o_mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_req_async", o_mem_req, 0);
        chk("rstmid_ready", o_ready, 1);
        i_mem_ack = 1'b1; i_mem_rdata = 8'h44;
        step();
        i_mem_ack = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rstmid_wb", o_wb_enable, 0);
            chk("rstmid_req", o_mem_req, 0);
            chk("rstmid_addr", o_mem_addr, 0);
            chk("rstmid_wb_data", o_wb_data, 0);
            chk("rstmid_fault", o_fault, 0);
        end

        // Randomised traffic against the transaction-level model
        fault_exp = 1'b0;
        for (int k = 0; k < 200; k++) begin
            op     = 2'($urandom);
            alu    = 8'($urandom);
            sd     = 8'($urandom);
            dest   = 2'($urandom);
            rd     = 8'($urandom);
            ack_at = $urandom_range(0, 17);
            run_instr(op, alu, sd, dest, ack_at, rd, n);

            is_mem = (op == OP_LOAD) || (op == OP_STORE);
            acked  = is_mem && ack_at >= 1 && ack_at <= TMO;
            e_en   = (op == OP_ALU) || (op == OP_LOAD && acked);
            if (is_mem && !acked) fault_exp = 1'b1;

            chk("rnd_nreq", n, is_mem ? (acked ? ack_at : TMO) : 0);
            chk("rnd_wb_en", o_wb_enable, e_en);
            chk("rnd_wb_dest", o_wb_dest_reg_addr, e_en ? dest : 2'd0);
            chk("rnd_wb_data", o_wb_data, !e_en ? 8'h00 : (op == OP_ALU) ? alu : rd);
            chk("rnd_fault", o_fault, fault_exp);
            chk("rnd_ready", o_ready, 1);

            // Occasional idle cycle with stray ack and/or fault clear
            if ($urandom_range(0, 3) == 0) begin
                i_mem_ack     = 1'($urandom);
                i_mem_rdata   = 8'($urandom);
                i_fault_clear = 1'($urandom);
                if (i_fault_clear) fault_exp = 1'b0;
                step();
                i_mem_ack     = 1'b0;
                i_fault_clear = 1'b0;
                chk("rnd_idle_wb", o_wb_enable, 0);
                chk("rnd_idle_req", o_mem_req, 0);
                chk("rnd_idle_fault", o_fault, fault_exp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
